// File: rtl/ifetch_pkg.sv
// Shared widths, types and helpers for the instruction fetch stage.
package ifetch_pkg;

    localparam int INST_WIDTH      = 32;
    localparam int INST_ADDR_WIDTH = 32;

    typedef logic [INST_WIDTH-1:0]      inst_t;
    typedef logic [INST_ADDR_WIDTH-1:0] addr_t;

    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned, so the low two bits of any target are dropped.
    function automatic addr_t align_pc(input addr_t pc);
        return pc & ~addr_t'(3);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle of the fetch stage: instruction-memory port, redirect input and IF/ID output.
interface ifetch_if;
    import ifetch_pkg::*;

    // imem: request accepted when imem_req_o & imem_gnt_i; responses return in order.
    // IF/ID: a word transfers when inst_valid_o & inst_ready_i; valid never depends on ready.
    logic  imem_req_o;
    addr_t imem_addr_o;
    logic  imem_gnt_i;
    logic  imem_rvalid_i;
    inst_t imem_rdata_i;
    logic  redirect_i;
    addr_t redirect_pc_i;
    logic  inst_valid_o;
    inst_t inst_o;
    addr_t inst_addr_o;
    logic  inst_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
    );

endinterface

// File: rtl/ifetch_buf.sv
// Allocate/fill/pop queue: entries are reserved at grant, filled by in-order responses,
// and popped in order once filled. Flush drops every entry in one cycle.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alloc,
    input  addr_t         alloc_addr,
    input  logic          fill,
    input  inst_t         fill_data,
    input  logic          pop,
    output logic          head_filled,
    output addr_t         head_addr,
    output inst_t         head_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    addr_t            addr_q [DEPTH];
    inst_t            data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    ptr_t             alloc_ptr;
    ptr_t             fill_ptr;
    ptr_t             pop_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            filled_q  <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            pop_ptr   <= '0;
            count     <= '0;
            pending   <= '0;
        end else begin
            if (alloc) begin
                filled_q[alloc_ptr] <= 1'b0;
                alloc_ptr           <= alloc_ptr + ptr_t'(1);
            end
            if (fill) begin
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + ptr_t'(1);
            end
            if (pop) begin
                filled_q[pop_ptr] <= 1'b0;
                pop_ptr           <= pop_ptr + ptr_t'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
            // Allocated but not yet filled: these are owed responses if a redirect hits.
            case ({alloc, fill})
                2'b10:   pending <= pending + cnt_t'(1);
                2'b01:   pending <= pending - cnt_t'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) addr_q[alloc_ptr] <= alloc_addr;
        if (fill)  data_q[fill_ptr]  <= fill_data;
    end

    assign head_filled = filled_q[pop_ptr];
    assign head_addr   = addr_q[pop_ptr];
    assign head_data   = data_q[pop_ptr];

endmodule

// File: rtl/ifetch.sv
// Fetch stage top: program counter, request issue, discard accounting for responses
// owed to flushed requests, and redirect control around the ifetch_buf queue.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = RESET_PC_DEFAULT,
    localparam int   CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_if.master      bus,
    output logic [CW-1:0] dbg_count,
    output logic [CW-1:0] dbg_discard,
    output addr_t         dbg_fetch_pc
);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   ext_t;

    localparam ext_t DEPTH_W = ext_t'(DEPTH);

    addr_t fetch_pc;
    cnt_t  count;
    cnt_t  pending;
    cnt_t  discard;
    cnt_t  discard_next;
    ext_t  inflight;
    ext_t  discard_sum;
    logic  grant;
    logic  fill;
    logic  pop;
    logic  head_filled;

    // Issue credit uses registered occupancy only; a same-cycle pop frees space next cycle.
    assign inflight        = ext_t'(count) + ext_t'(discard);
    assign bus.imem_req_o  = ~rst & ~bus.redirect_i & (inflight < DEPTH_W);
    assign bus.imem_addr_o = fetch_pc;
    assign grant           = bus.imem_req_o & bus.imem_gnt_i;
    assign fill            = bus.imem_rvalid_i & ~bus.redirect_i & (discard == '0);

    assign bus.inst_valid_o = head_filled & ~bus.redirect_i;
    assign pop              = bus.inst_valid_o & bus.inst_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_i) begin
            fetch_pc <= align_pc(bus.redirect_pc_i);
        end else if (grant) begin
            fetch_pc <= fetch_pc + addr_t'(4);
        end
    end

    // On redirect every unfilled entry becomes an owed response; one arriving now is dropped.
    always_comb begin
        discard_next = discard;
        discard_sum  = ext_t'(discard) + ext_t'(pending) - ext_t'(bus.imem_rvalid_i);
        if (bus.redirect_i) begin
            discard_next = discard_sum[CW-1:0];
        end else if (bus.imem_rvalid_i && (discard != '0)) begin
            discard_next = discard - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard <= '0;
        end else begin
            discard <= discard_next;
        end
    end

    ifetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (bus.redirect_i),
        .alloc       (grant),
        .alloc_addr  (fetch_pc),
        .fill        (fill),
        .fill_data   (bus.imem_rdata_i),
        .pop         (pop),
        .head_filled (head_filled),
        .head_addr   (bus.inst_addr_o),
        .head_data   (bus.inst_o),
        .count       (count),
        .pending     (pending)
    );

    assign dbg_count    = count;
    assign dbg_discard  = discard;
    assign dbg_fetch_pc = fetch_pc;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: an in-order memory model that returns each address as its
// data, and a linear sequence of steps checked with immediate assertions.
module tb_ifetch;
    import ifetch_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  dbg_count;
    logic [2:0]  dbg_discard;
    addr_t       dbg_fetch_pc;

    ifetch_if bus ();

    ifetch #(.DEPTH(4), .RESET_PC(RESET_PC_DEFAULT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_count    (dbg_count),
        .dbg_discard  (dbg_discard),
        .dbg_fetch_pc (dbg_fetch_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int grant_cnt = 0;
    int lat   = 1;
    int g0;
    logic [31:0] exp_q[$];

    typedef struct {
        addr_t addr;
        int    due;
    } rsp_t;
    rsp_t rsp_q[$];
    rsp_t rsp_new;

    // memory model: in-order responses lat cycles after grant, data = address
    always @(posedge clk) begin
        if (rst) begin
            rsp_q.delete();
        end else begin
            if (bus.imem_rvalid_i && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                rsp_new.addr = bus.imem_addr_o;
                rsp_new.due  = cyc + lat;
                rsp_q.push_back(rsp_new);
                grant_cnt++;
            end
        end
        cyc++;
        #1;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = rsp_q[0].addr;
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut(input int l, input logic g, input logic r);
        rst = 1'b1;
        bus.redirect_i = 1'b0;
        tick(2);
        lat = l;
        bus.imem_gnt_i = g;
        bus.inst_ready_i = r;
        rst = 1'b0;
    endtask

    // scoreboard comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.imem_gnt_i    = 1'b1;
        bus.inst_ready_i  = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        tick(3);

        // reset state
        chk("rst_req", bus.imem_req_o, 0);
        chk("rst_valid", bus.inst_valid_o, 0);
        chk("rst_addr", bus.imem_addr_o, RESET_PC_DEFAULT);
        chk("rst_count", dbg_count, 0);
        chk("rst_discard", dbg_discard, 0);
        chk("rst_pc", dbg_fetch_pc, RESET_PC_DEFAULT);

        // streaming, L=1
        rst = 1'b0;
        #1;
        chk("first_req", bus.imem_req_o, 1);
        chk("first_addr", bus.imem_addr_o, 0);
        tick(1);
        chk("stream_lat", bus.inst_valid_o, 0);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("stream_valid", bus.inst_valid_o, 1);
            chk("stream_addr", bus.inst_addr_o, 32'(4 * k));
            chk("stream_data", bus.inst_o, 32'(4 * k));
        end

        // mid-stream reset
        rst = 1'b1;
        tick(1);
        chk("mr_valid", bus.inst_valid_o, 0);
        chk("mr_req", bus.imem_req_o, 0);
        chk("mr_addr", bus.imem_addr_o, RESET_PC_DEFAULT);
        chk("mr_count", dbg_count, 0);
        bus.inst_ready_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("mr_first_req", bus.imem_req_o, 1);
        chk("mr_first_addr", bus.imem_addr_o, RESET_PC_DEFAULT);
        g0 = grant_cnt;

        // downstream stall for 10 cycles
        tick(2);
        chk("stall_valid", bus.inst_valid_o, 1);
        chk("stall_head", bus.inst_addr_o, 0);
        tick(8);
        chk("stall_grants", 32'(grant_cnt - g0), 4);
        chk("stall_req", bus.imem_req_o, 0);
        chk("stall_head_held", bus.inst_addr_o, 0);
        chk("stall_count", dbg_count, 4);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        bus.inst_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick(1);
            chk("release_valid", bus.inst_valid_o, 1);
            chk("release_addr", bus.inst_addr_o, exp_q.pop_front());
        end

        // memory back-pressure: gnt low for 5 cycles
        reset_dut(1, 1'b0, 1'b1);
        #1;
        g0 = grant_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick(1);
            chk("bp_addr", bus.imem_addr_o, 0);
            chk("bp_req", bus.imem_req_o, 1);
            chk("bp_pc", dbg_fetch_pc, 0);
            chk("bp_valid", bus.inst_valid_o, 0);
        end
        chk("bp_no_grant", 32'(grant_cnt - g0), 0);
        tick(1);
        bus.imem_gnt_i = 1'b1;
        #1;
        chk("bp_resume_addr", bus.imem_addr_o, 0);
        tick(1);
        chk("bp_next_addr", bus.imem_addr_o, 4);
        chk("bp_one_grant", 32'(grant_cnt - g0), 1);
        tick(1);
        chk("bp_out0_valid", bus.inst_valid_o, 1);
        chk("bp_out0_addr", bus.inst_addr_o, 0);
        tick(1);
        chk("bp_out1_addr", bus.inst_addr_o, 4);

        // redirect with two unfilled entries, L=3
        reset_dut(3, 1'b1, 1'b1);
        tick(2);
        chk("rd_pre_count", dbg_count, 2);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0000_0100;
        #1;
        chk("rd_req_masked", bus.imem_req_o, 0);
        chk("rd_valid_masked", bus.inst_valid_o, 0);
        tick(1);
        bus.redirect_i = 1'b0;
        #1;
        chk("rd_discard2", dbg_discard, 2);
        chk("rd_count0", dbg_count, 0);
        chk("rd_new_addr", bus.imem_addr_o, 32'h100);
        chk("rd_req", bus.imem_req_o, 1);
        tick(1);
        chk("rd_discard1", dbg_discard, 1);
        chk("rd_stale1", bus.inst_valid_o, 0);
        tick(1);
        chk("rd_discard0", dbg_discard, 0);
        chk("rd_stale2", bus.inst_valid_o, 0);
        tick(1);
        chk("rd_early", bus.inst_valid_o, 0);
        tick(1);
        chk("rd_out0_valid", bus.inst_valid_o, 1);
        chk("rd_out0_addr", bus.inst_addr_o, 32'h100);
        chk("rd_out0_data", bus.inst_o, 32'h100);
        tick(1);
        chk("rd_out1_valid", bus.inst_valid_o, 1);
        chk("rd_out1_addr", bus.inst_addr_o, 32'h104);

        // redirect coinciding with a response, L=2, unaligned target
        reset_dut(2, 1'b1, 1'b1);
        tick(2);
        chk("rr_pre_count", dbg_count, 2);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0000_0203;
        tick(1);
        bus.redirect_i = 1'b0;
        #1;
        chk("rr_discard1", dbg_discard, 1);
        chk("rr_count0", dbg_count, 0);
        chk("rr_aligned_addr", bus.imem_addr_o, 32'h200);
        chk("rr_stale1", bus.inst_valid_o, 0);
        tick(1);
        chk("rr_discard0", dbg_discard, 0);
        chk("rr_stale2", bus.inst_valid_o, 0);
        tick(1);
        chk("rr_early", bus.inst_valid_o, 0);
        tick(1);
        chk("rr_out0_valid", bus.inst_valid_o, 1);
        chk("rr_out0_addr", bus.inst_addr_o, 32'h200);
        chk("rr_out0_data", bus.inst_o, 32'h200);
        tick(1);
        chk("rr_out1_addr", bus.inst_addr_o, 32'h204);

        // back-to-back redirects, last one wraps the PC
        reset_dut(1, 1'b1, 1'b1);
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h0000_0040;
        #1;
        chk("bb_req_masked", bus.imem_req_o, 0);
        tick(1);
        bus.redirect_pc_i = 32'hFFFF_FFFE;
        tick(1);
        bus.redirect_i = 1'b0;
        #1;
        chk("bb_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        chk("bb_discard", dbg_discard, 0);
        tick(1);
        chk("wrap_addr", bus.imem_addr_o, 32'h0000_0000);
        tick(1);
        chk("wrap_out0_valid", bus.inst_valid_o, 1);
        chk("wrap_out0_addr", bus.inst_addr_o, 32'hFFFF_FFFC);
        tick(1);
        chk("wrap_out1_addr", bus.inst_addr_o, 32'h0000_0000);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
